// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-period helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;

   // Whole clocks per bit period (integer division); shared with baud_gen.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all-ones (idle-high lines).
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Metastability chain: first flop may go metastable, second presents a clean level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-edge re-phased mid-bit sampling.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_line,
   output logic [7:0] o_data_out,
   output logic       o_valid,
   output logic       o_busy,
   output logic       o_frame_err,
   output logic       o_parity_err
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic              w_rx_s;
   uart_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [2:0]        r_bit_idx, w_bit_idx_nxt;
   logic [7:0]        r_shift, w_shift_nxt;
   logic [7:0]        r_data, w_data_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_frame_err, w_frame_err_nxt;
   logic              w_par_bad;
`ifdef UART_RX_PARITY_EN
   logic              r_par_bit, w_par_bit_nxt;
   logic              r_parity_err, w_parity_err_nxt;
`endif

   sync_2ff #(
      .WIDTH (1)
   ) u_sync_rx (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx_line),
      .o_q   (w_rx_s)
   );

`ifdef UART_RX_PARITY_EN
   // Even parity: data XOR parity bit must be zero.
   assign w_par_bad = r_par_bit ^ (^r_shift);
`else
   assign w_par_bad = 1'b0;
`endif

   // State and datapath registers; reset abandons any partial frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_shift      <= w_shift_nxt;
         r_data       <= w_data_nxt;
         r_valid      <= w_valid_nxt;
         r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= w_par_bit_nxt;
         r_parity_err <= w_parity_err_nxt;
`endif
      end
   end

   // Next-state logic: half-bit start qualification, then full-bit steps to each bit centre.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_data_nxt      = r_data;
      w_valid_nxt     = 1'b0;
      w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bit_nxt    = r_par_bit;
      w_parity_err_nxt = 1'b0;
`endif
      unique case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            if (!w_rx_s) w_state_nxt = StStart;
         end
         StStart: begin
            if (r_cnt == HALF_END) begin
               w_cnt_nxt     = '0;
               w_bit_idx_nxt = '0;
               // Line back high at the start-bit centre means it was a glitch.
               w_state_nxt   = w_rx_s ? StIdle : StData;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StData: begin
            if (r_cnt == BIT_END) begin
               w_cnt_nxt     = '0;
               w_shift_nxt   = {w_rx_s, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = StParity;
`else
                  w_state_nxt = StStop;
`endif
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StParity: begin
`ifdef UART_RX_PARITY_EN
            if (r_cnt == BIT_END) begin
               w_cnt_nxt     = '0;
               w_par_bit_nxt = w_rx_s;
               w_state_nxt   = StStop;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`else
            w_state_nxt = StIdle;
`endif
         end
         StStop: begin
            if (r_cnt == BIT_END) begin
               w_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
               w_parity_err_nxt = w_par_bad;
`endif
               if (w_rx_s) begin
                  w_state_nxt = StIdle;
                  if (!w_par_bad) begin
                     w_data_nxt  = r_shift;
                     w_valid_nxt = 1'b1;
                  end
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = StBreak;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StBreak: begin
            // Hold off until the line idles so a stuck-low line cannot re-trigger.
            w_cnt_nxt = '0;
            if (w_rx_s) w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_data_out  = r_data;
   assign o_valid     = r_valid;
   assign o_busy      = (r_state != StIdle);
   assign o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames against a byte-queue reference model.
module tb_uart_rx;

   localparam int unsigned CLK_HZ = 5_000_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam int EXP_PERR   = 1;
`else
   localparam int FRAME_BITS = 10;
   localparam int EXP_PERR   = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       parity_err;

   uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_line    (rx_line),
      .o_data_out   (data_out),
      .o_valid      (valid),
      .o_busy       (busy),
      .o_frame_err  (frame_err),
      .o_parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int n_perr   = 0;
   logic [7:0] exp_q[$];
   int         valid_cycs[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every valid pulse must deliver the oldest byte still owed by the model.
   always @(negedge clk) begin
      if (valid || frame_err) check("valid_ferr_exclusive", 32'(valid & frame_err), 0);
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (valid) begin
         n_valid++;
         valid_cycs.push_back(cyc);
         check("valid_byte_owed", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("rx_byte", 32'(data_out), 32'(exp_q.pop_front()));
      end
   end

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drive one frame; rst_bit >= 0 pulses reset half-way through that frame bit and stops.
   task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_val,
                             input logic par_flip, input int rst_bit);
      logic [10:0] bits;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
      bits[9]   = (^b) ^ par_flip;
      bits[10]  = stop_val;
`else
      bits[9]   = stop_val | par_flip;
`endif
      for (int i = 0; i < FRAME_BITS; i++) begin
         rx_line = bits[i];
         if (i == rst_bit) begin
            repeat (bit_clks / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_data_out", 32'(data_out), 0);
            check("rst_valid", 32'(valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_frame_err", 32'(frame_err), 0);
            check("rst_parity_err", 32'(parity_err), 0);
            rst = 1'b0;
            rx_line = 1'b1;
            return;
         end
         repeat (bit_clks) @(negedge clk);
      end
   endtask

   task automatic send_good(input logic [7:0] b, input int bit_clks);
      exp_q.push_back(b);
      send_frame(b, bit_clks, 1'b1, 1'b0, -1);
   endtask

   initial begin
      logic [7:0] last_good;
      int         t0, nv0, nf0, lat, lat_exp, fall_at, d, bt;
      logic       saw_busy, fell;

      // Reset state
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_data_out", 32'(data_out), 0);
      check("reset_valid", 32'(valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_frame_err", 32'(frame_err), 0);
      check("reset_parity_err", 32'(parity_err), 0);
      idle(10);

      // Two clean frames, first one timed from its falling edge
      nv0 = n_valid;
      valid_cycs.delete();
      t0 = cyc;
      send_good(8'hA5, CPB);
      idle(20);
      send_good(8'h3C, CPB);
      idle(20);
      last_good = 8'h3C;
      check("clean_valid_count", n_valid - nv0, 2);
      check("clean_no_frame_err", n_ferr, 0);
      lat_exp = 2 + HALF + (FRAME_BITS - 1) * CPB;
      lat = (valid_cycs.size() != 0) ? valid_cycs[0] - t0 : -1;
      check("a5_latency_pm1", (lat >= lat_exp - 1 && lat <= lat_exp + 1) ? lat_exp : lat, lat_exp);

      // Short low glitch: must be rejected at the start-bit centre
      nv0 = n_valid;
      nf0 = n_ferr;
      saw_busy = 1'b0;
      fell = 1'b0;
      fall_at = -1;
      rx_line = 1'b0;
      t0 = cyc;
      for (int i = 0; i < HALF + 20; i++) begin
         @(negedge clk);
         if (i == 9) rx_line = 1'b1;
         if (busy) saw_busy = 1'b1;
         if (saw_busy && !busy && !fell) begin
            fell = 1'b1;
            fall_at = cyc - t0;
         end
      end
      check("glitch_busy_rose", 32'(saw_busy), 1);
      check("glitch_busy_fall_time", (fell && fall_at <= HALF + 3) ? 1 : fall_at, 1);
      check("glitch_no_valid", n_valid - nv0, 0);
      check("glitch_no_frame_err", n_ferr - nf0, 0);
      check("glitch_data_hold", 32'(data_out), 32'(last_good));

      // Framing error with the line held low afterwards
      nv0 = n_valid;
      nf0 = n_ferr;
      send_frame(8'h55, CPB, 1'b0, 1'b0, -1);
      rx_line = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      check("break_holds_busy", 32'(busy), 1);
      idle(20);
      check("break_released", 32'(busy), 0);
      check("frame_err_once", n_ferr - nf0, 1);
      check("frame_err_no_valid", n_valid - nv0, 0);
      check("frame_err_data_hold", 32'(data_out), 32'(last_good));
      send_good(8'hC3, CPB);
      idle(20);
      last_good = 8'hC3;
      check("after_break_data", 32'(data_out), 32'(last_good));

      // Reset in the middle of data bit 4
      nv0 = n_valid;
      send_frame(8'hFF, CPB, 1'b1, 1'b0, 5);
      idle(3 * CPB);
      check("rst_frame_discarded", n_valid - nv0, 0);
      send_good(8'h81, CPB);
      idle(20);
      last_good = 8'h81;
      check("after_rst_data", 32'(data_out), 32'(last_good));

      // Back-to-back random bytes with slow then fast transmitter
      for (int run = 0; run < 2; run++) begin
         bt = (run == 0) ? CPB + CPB / 50 : CPB - CPB / 50;
         nv0 = n_valid;
         valid_cycs.delete();
         for (int k = 0; k < 16; k++) begin
            last_good = 8'($urandom);
            send_good(last_good, bt);
         end
         idle(3 * CPB);
         check("b2b_count", n_valid - nv0, 16);
         for (int k = 1; k < valid_cycs.size(); k++) begin
            d = valid_cycs[k] - valid_cycs[k-1];
            check("b2b_spacing", (d >= FRAME_BITS * bt - 2 && d <= FRAME_BITS * bt + 2) ?
                  FRAME_BITS * bt : d, FRAME_BITS * bt);
         end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: correct bit accepted, flipped bit rejected
      send_good(8'h07, CPB);
      idle(20);
      last_good = 8'h07;
      check("parity_ok_data", 32'(data_out), 32'(last_good));
      nv0 = n_valid;
      send_frame(8'h07, CPB, 1'b1, 1'b1, -1);
      idle(20);
      check("parity_bad_no_valid", n_valid - nv0, 0);
      check("parity_bad_data_hold", 32'(data_out), 32'(last_good));
`endif

      check("model_queue_drained", exp_q.size(), 0);
      check("parity_err_count", n_perr, EXP_PERR);
      check("frame_err_total", n_ferr, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
